// File: rtl/uart_alu.sv
// UART-attached 8-bit ALU: 8N1 receiver, opcode parser/ALU, small TX byte FIFO, 8N1 transmitter.
// Each command packet yields its response bytes on tx_o, low result byte first.
module uart_alu #(
  parameter int CLKS_PER_BIT  = 280,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic tx_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_GET_A, P_GET_B, P_ECHO, P_EMIT} p_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------- RX: synchronizer and receiver ----------------
  logic            rx_meta, rx_sync, rx_prev;
  rx_state_t       rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_sync) begin
          rx_cnt   <= '0;
          rx_state <= RX_START;
        end
        RX_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_sync ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_bit   <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_STOP: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_valid <= rx_sync;
          // A low stop bit is a framing error: drop the byte and re-arm only once the line idles.
          rx_state <= rx_sync ? RX_IDLE : RX_WAIT;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_WAIT: if (rx_sync) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Parser / ALU ----------------
  p_state_t    p_state;
  logic [7:0]  opcode, op_a;
  logic [15:0] result;
  logic        emit_hi;
  logic        push;
  logic [7:0]  push_data;
  logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_full, fifo_empty;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  function automatic logic is_alu_op(input logic [7:0] op);
    return (op >= 8'h01) && (op <= 8'h06);
  endfunction

  function automatic logic [15:0] alu(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      8'h01:   return {8'h00, a} + {8'h00, b};
      8'h02:   return {8'h00, a} - {8'h00, b};
      8'h03:   return {8'h00, a & b};
      8'h04:   return {8'h00, a | b};
      8'h05:   return {8'h00, a ^ b};
      8'h06:   return a * b;
      default: return 16'h0000;
    endcase
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    push      = 1'b0;
    push_data = result[7:0];
    case (p_state)
      P_IDLE: if (rx_valid && !is_alu_op(rx_shift) && rx_shift != 8'hEC) begin
        push      = !fifo_full;
        push_data = 8'hEE;
      end
      P_ECHO: if (rx_valid) begin
        push      = !fifo_full;
        push_data = rx_shift;
      end
      P_EMIT: begin
        push      = !fifo_full;
        push_data = emit_hi ? result[15:8] : result[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_state <= P_IDLE;
      opcode  <= '0;
      op_a    <= '0;
      result  <= '0;
      emit_hi <= 1'b0;
      wr_ptr  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case (p_state)
        P_IDLE: if (rx_valid) begin
          opcode <= rx_shift;
          if (is_alu_op(rx_shift))     p_state <= P_GET_A;
          else if (rx_shift == 8'hEC)  p_state <= P_ECHO;
        end
        P_GET_A: if (rx_valid) begin
          op_a    <= rx_shift;
          p_state <= P_GET_B;
        end
        P_GET_B: if (rx_valid) begin
          result  <= alu(opcode, op_a, rx_shift);
          emit_hi <= 1'b0;
          p_state <= P_EMIT;
        end
        P_ECHO: if (rx_valid) p_state <= P_IDLE;
        // Bytes arriving while stalled here are not looked at, i.e. dropped.
        P_EMIT: if (push) begin
          emit_hi <= 1'b1;
          if (emit_hi) p_state <= P_IDLE;
        end
        default: p_state <= P_IDLE;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; the cleared pointers already mark every entry invalid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // ---------------- TX ----------------
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      rd_ptr   <= '0;
      tx_o     <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_o <= 1'b1;
          if (!fifo_empty) begin
            tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
            rd_ptr   <= rd_ptr + 1'b1;
            tx_o     <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          tx_o     <= tx_shift[0];
          tx_state <= TX_DATA;
        end else tx_cnt <= tx_cnt + 1'b1;
        TX_DATA: if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_bit   <= tx_bit + 1'b1;
          tx_shift <= {1'b0, tx_shift[7:1]};
          if (tx_bit == 3'd7) begin
            tx_o     <= 1'b1;
            tx_state <= TX_STOP;
          end else tx_o <= tx_shift[1];
        end else tx_cnt <= tx_cnt + 1'b1;
        TX_STOP: if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          // Chain the next frame straight after the stop bit when more bytes are queued.
          if (!fifo_empty) begin
            tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
            rd_ptr   <= rd_ptr + 1'b1;
            tx_o     <= 1'b0;
            tx_state <= TX_START;
          end else tx_state <= TX_IDLE;
        end else tx_cnt <= tx_cnt + 1'b1;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_alu.sv
// Directed bench for uart_alu: serial stimulus on rx, frame decoder on tx, hand-computed responses.
module tb_uart_alu;
  localparam int CPB = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;
  int   cyc = 0;

  int   total = 0;
  int   bad   = 0;

  logic [7:0] resp_q [$];
  int   frames     = 0;
  int   tim_err    = 0;
  int   frame_err  = 0;
  int   fall_cyc   = 0;
  int   stop_cyc   = 0;

  uart_alu #(.CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rx_i (rx),
    .tx_o (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame decoder: each bit must hold one value from its first to its last cycle.
  initial begin
    logic [9:0] mid, beg_v, end_v;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        fall_cyc = cyc;
        beg_v[0] = tx;
        for (int k = 1; k < 10 * CPB; k++) begin
          @(negedge clk);
          if (k % CPB == 0)       beg_v[k / CPB] = tx;
          if (k % CPB == CPB / 2) mid[k / CPB]   = tx;
          if (k % CPB == CPB - 1) end_v[k / CPB] = tx;
        end
        mid[0] = beg_v[0];
        if (CPB / 2 != 0) begin
          for (int i = 0; i < 10; i++)
            if (beg_v[i] !== mid[i] || end_v[i] !== mid[i]) tim_err++;
        end
        if (mid[9] !== 1'b1) frame_err++;
        frames++;
        resp_q.push_back(mid[8:1]);
      end
    end
  end

  // Called at a negedge; leaves rx idle-high at a negedge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    stop_cyc = cyc;
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic expect_resp(input string tag, input int n, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] exp_b [2];
    logic [7:0] got;
    int budget;
    exp_b[0] = b0;
    exp_b[1] = b1;
    budget = 30 * CPB;
    while (resp_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (12 * CPB) @(negedge clk);
    check({tag, "_count"}, resp_q.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), got, exp_b[i]);
    end
    resp_q.delete();
  endtask

  initial begin
    // Reset: tx idle high throughout, then a long quiet period.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_tx_high", tx, 1'b1);
    end
    rst = 1'b0;
    repeat (10000) @(negedge clk);
    check("idle_no_frames", frames, 0);
    check("idle_tx_high", tx, 1'b1);

    // Echo, with bit timing and start-bit latency.
    send_byte(8'hEC);
    send_byte(8'h5A);
    expect_resp("echo", 1, 8'h5A, 8'h00);
    check("echo_latency_ok", (fall_cyc - stop_cyc) <= (CPB / 2 + 7), 1'b1);
    check("echo_bit_timing", tim_err, 0);
    check("echo_stop_bit", frame_err, 0);

    // ADD with carry, SUB wrapping.
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'h02);
    expect_resp("add", 2, 8'h01, 8'h01);
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h02);
    expect_resp("sub", 2, 8'hFF, 8'hFF);

    // MUL full range, XOR.
    send_byte(8'h06); send_byte(8'hFF); send_byte(8'hFF);
    expect_resp("mul", 2, 8'h01, 8'hFE);
    send_byte(8'h05); send_byte(8'hF0); send_byte(8'h3C);
    expect_resp("xor", 2, 8'hCC, 8'h00);

    // Unknown opcode; framing error dropped; echo still works afterwards.
    send_byte(8'h77);
    expect_resp("bad_op", 1, 8'hEE, 8'h00);
    send_byte(8'hEC, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'hEC);
    send_byte(8'h11);
    expect_resp("frame_err", 1, 8'h11, 8'h00);

    // Reset mid-packet aborts it; fresh AND afterwards.
    send_byte(8'h01); send_byte(8'h10);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_tx_high", tx, 1'b1);
    rst = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    check("midreset_silent", resp_q.size(), 0);
    send_byte(8'h03); send_byte(8'hF0); send_byte(8'h0F);
    expect_resp("and", 2, 8'h00, 8'h00);

    // Low glitch shorter than half a bit is rejected.
    rx = 1'b0;
    repeat (CPB / 2 - 4) @(negedge clk);
    rx = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    check("glitch_ignored", resp_q.size(), 0);
    send_byte(8'hEC); send_byte(8'h3C);
    expect_resp("post_glitch", 1, 8'h3C, 8'h00);

    check("final_bit_timing", tim_err, 0);
    check("final_stop_bits", frame_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
